// File: rtl/board_scanner.sv
// board_scanner: snapshots the 16-cell game board (and optionally the score),
// converts every cell to a 5-bit log2 tile code and streams the frame out
// over a valid/ready interface, one beat per cell.
// Optional feature macro: SCORE_BCD_EN -- when defined, the snapshot score is
// converted to BCD by sequential double-dabble and appended as BCD_DIGITS
// extra beats (out_idx 16..), most significant digit first.
module board_scanner #(
  parameter bit AUTO_REFRESH = 1'b1,
  parameter int BCD_DIGITS   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] board,
  input  logic [20:0]  score,
  input  logic         frame_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_idx,
  output logic [4:0]   out_data,
  output logic         out_last,
  output logic         busy,
  output logic         bad_tile
);

  localparam logic [4:0] NUM_CELLS = 5'd16;
  localparam logic [4:0] LAST_CELL = 5'd15;
  localparam logic [4:0] BAD_CODE  = 5'd31;

`ifdef SCORE_BCD_EN
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SCAN, S_CONV, S_DIGITS} state_t;
  localparam int BCD_W = 4 * BCD_DIGITS;
`else
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN} state_t;
`endif

  state_t         state_q;
  logic [319:0]   snap_board_q;
  logic [4:0]     cnt_q;
  logic           pending_q;
  logic           out_valid_q;
  logic [4:0]     out_idx_q;
  logic [4:0]     out_data_q;
  logic           out_last_q;
  logic           bad_tile_q;

  logic [19:0]    cell_val_d;
  logic [4:0]     cell_code_d;
  logic           cell_last_d;
  logic           start_d;

  // log2 of a power of two in 2..2^19, 0 for an empty cell, BAD_CODE otherwise.
  function automatic logic [4:0] tile_code(input logic [19:0] v);
    logic [4:0] code;
    code = BAD_CODE;
    if (v == 20'd0) code = 5'd0;
    else
      for (int k = 1; k < 20; k++)
        if (v == (20'd1 << k)) code = 5'(k);
    return code;
  endfunction

  // Select the snapshot cell addressed by the beat counter and encode it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cell_val_d = '0;
    for (int i = 0; i < 16; i++)
      if (cnt_q[3:0] == 4'(i)) cell_val_d = snap_board_q[20*i +: 20];
    cell_code_d = tile_code(cell_val_d);
`ifdef SCORE_BCD_EN
    cell_last_d = 1'b0;
`else
    cell_last_d = (cnt_q == LAST_CELL);
`endif
    start_d = frame_req | pending_q | (AUTO_REFRESH && (board != snap_board_q));
  end

`ifdef SCORE_BCD_EN
  logic [20:0]      snap_score_q;
  logic [20:0]      bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj_d;
  logic [4:0]       dd_cnt_q;
  logic [3:0]       digit_d;

  // Double-dabble add-3 correction and output digit selection (MSD first).
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int n = 0; n < BCD_DIGITS; n++)
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj_d[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    digit_d = '0;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (cnt_q == 5'(d)) digit_d = bcd_q[BCD_W-4-4*d +: 4];
  end
`else
  logic unused_score;
  assign unused_score = ^{score, 5'(BCD_DIGITS)};
`endif

  // Frame sequencer: capture, per-cell beats, optional score digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot is reset so AUTO_REFRESH compares against a known zero board.
      state_q      <= S_IDLE;
      snap_board_q <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      bad_tile_q   <= 1'b0;
`ifdef SCORE_BCD_EN
      snap_score_q <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      dd_cnt_q     <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
      if (frame_req && (state_q != S_IDLE)) pending_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q   <= S_CAPTURE;
            pending_q <= 1'b0;
          end
        end
        S_CAPTURE: begin
          snap_board_q <= board;
`ifdef SCORE_BCD_EN
          snap_score_q <= score;
`endif
          cnt_q   <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (!out_valid_q || out_ready) begin
            if (cnt_q != NUM_CELLS) begin
              out_valid_q <= 1'b1;
              out_idx_q   <= cnt_q;
              out_data_q  <= cell_code_d;
              out_last_q  <= cell_last_d;
              if (cell_code_d == BAD_CODE) bad_tile_q <= 1'b1;
              cnt_q <= cnt_q + 5'd1;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
`ifdef SCORE_BCD_EN
              state_q  <= S_CONV;
              bin_q    <= snap_score_q;
              bcd_q    <= '0;
              dd_cnt_q <= '0;
`else
              state_q <= S_IDLE;
`endif
            end
          end
        end
`ifdef SCORE_BCD_EN
        S_CONV: begin
          if (dd_cnt_q == 5'd21) begin
            cnt_q   <= '0;
            state_q <= S_DIGITS;
          end else begin
            bcd_q    <= {bcd_adj_d[BCD_W-2:0], bin_q[20]};
            bin_q    <= {bin_q[19:0], 1'b0};
            dd_cnt_q <= dd_cnt_q + 5'd1;
          end
        end
        S_DIGITS: begin
          if (!out_valid_q || out_ready) begin
            if (cnt_q != 5'(BCD_DIGITS)) begin
              out_valid_q <= 1'b1;
              out_idx_q   <= 5'd16 + cnt_q;
              out_data_q  <= {1'b0, digit_d};
              out_last_q  <= (cnt_q == 5'(BCD_DIGITS - 1));
              cnt_q       <= cnt_q + 5'd1;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign bad_tile  = bad_tile_q;

endmodule
